// File: rtl/seg7_pkg.sv
// seg7_pkg: segment glyphs, lost-mode phase enum and BCD-to-glyph helper
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_Y     = 7'b1101110;
    localparam logic [6:0] SEG_O     = 7'b0111111;
    localparam logic [6:0] SEG_U     = 7'b0111110;
    localparam logic [6:0] SEG_L     = 7'b0111000;
    localparam logic [6:0] SEG_S     = 7'b1101101;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {P_YOU, P_BLANK_A, P_LOSE, P_BLANK_B} phase_e;

    // Active-high {g..a} glyph of a BCD nibble; non-decimal codes show a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: game-side controls and board display pins of the scan driver
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 4);
    logic                    en;
    logic                    lost;
    logic [4*NUM_DIGITS-1:0] score_bcd;
    logic [NUM_DIGITS-1:0]   Anode_Activate;
    logic [6:0]              LED_out;

    modport master (output en, lost, score_bcd, input Anode_Activate, LED_out);
    modport slave  (input en, lost, score_bcd, output Anode_Activate, LED_out);
endinterface

// File: rtl/seg7_prescaler.sv
// seg7_prescaler: free-running 0..DIV-1 counter with terminal-count tick and sync clear
module seg7_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == W'(DIV - 1);

    // Wrap on the terminal count so the counter never passes DIV-1
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;

    // Count register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment driver for score and blinking YOU/LOSE message
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic                  ref_tick, blink_tick, rise, lost_q, z;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d, lz;
    logic [6:0]            led_q, led_d, score_seg, msg_seg;
    logic [3:0]            nib [NUM_DIGITS];
    phase_e                phase_q;

    assign rise = bus.lost & ~lost_q;

    seg7_prescaler #(.DIV(REFRESH_DIV)) u_refresh (
        .clk(clk), .rst(rst), .clr(1'b0), .tick(ref_tick)
    );

    seg7_prescaler #(.DIV(BLINK_DIV)) u_blink (
        .clk(clk), .rst(rst), .clr(~bus.lost | rise), .tick(blink_tick)
    );

    // Split the score into nibbles and flag digits with only zeros at or above them
    always_comb begin
        z  = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib[i] = bus.score_bcd[4*i +: 4];
            z      = z & (nib[i] == 4'd0);
            lz[i]  = z;
        end
    end

    // Glyph for the scanned digit in each mode; digit 0 is never blanked
    always_comb begin
        score_seg = (LZ_BLANK && lz[idx_q] && idx_q != '0) ? SEG_BLANK : bcd_to_seg(nib[idx_q]);
        msg_seg   = phase_q == P_YOU  ? (idx_q == IW'(2) ? SEG_Y :
                                         idx_q == IW'(1) ? SEG_O :
                                         idx_q == IW'(0) ? SEG_U : SEG_BLANK) :
                    phase_q == P_LOSE ? (idx_q == IW'(3) ? SEG_L :
                                         idx_q == IW'(2) ? SEG_O :
                                         idx_q == IW'(1) ? SEG_S :
                                         idx_q == IW'(0) ? SEG_E : SEG_BLANK) : SEG_BLANK;
    end

    // Next digit index and the active-low pin values for the current slot
    always_comb begin
        idx_d   = ref_tick ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        anode_d = bus.en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        led_d   = bus.en ? ~(bus.lost ? msg_seg : score_seg) : 7'h7F;
    end

    // Lost-mode phase sequencer; a fresh loss always restarts at YOU
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lost_q  <= 1'b0;
            phase_q <= P_YOU;
        end else begin
            lost_q <= bus.lost;
            if (!bus.lost || rise) phase_q <= P_YOU;
            else if (blink_tick)   phase_q <= phase_e'(phase_q + 2'd1);
        end

    // Scan index and registered display pins
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx_q   <= '0;
            anode_q <= '1;
            led_q   <= 7'h7F;
        end else begin
            idx_q   <= idx_d;
            anode_q <= anode_d;
            led_q   <= led_d;
        end

    assign bus.Anode_Activate = anode_q;
    assign bus.LED_out        = led_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed seven-segment driver for the game's score/status display.
- Time-multiplexes NUM_DIGITS common-anode digits from one system clock, with internal refresh and blink prescalers.
- Score mode shows a packed BCD score.
- Lost mode cycles a blinking "YOU" / "LOSE" message.
- Sits between the game FSM (score_bcd, lost) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits; legal values are >= 4.
- REFRESH_DIV, 100000, clk cycles per digit slot; legal values are >= 2.
- BLINK_DIV, 50000000, clk cycles per lost-mode message phase; legal values are >= 2.
- LZ_BLANK, 1, when 1, leading zeros in score mode are blanked.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  display enable; when 0, all digits are dark but counters keep running.
- lost  in  1  level from the game FSM; 1 selects lost mode.
- score_bcd  in  4*NUM_DIGITS  packed BCD score; digit 0 is bits [3:0] and is the rightmost digit.
- Anode_Activate  out  NUM_DIGITS  active-low digit enables; bit i drives digit i.
- LED_out  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.

Behaviour:
- Reset: rst asserted clears state immediately, independent of clk.
  - Anode_Activate = all ones and LED_out = 7'h7F.
  - Refresh and blink prescalers = 0, digit index = 0, phase = P_YOU, lost_q = 0.
  - Reset mid-scan or mid-phase has the same effect. After release, the scan starts at digit 0.
- Refresh prescaler: counts 0..REFRESH_DIV-1. On the terminal count it wraps to 0 and the digit index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
- Outputs are registered. Anode_Activate and LED_out reflect the index, mode and data of the previous cycle, so latency is 1 clk.
- Exactly one anode bit is low at a time, namely bit index. All anode bits are high when en = 0.
- Score mode (lost = 0):
  - The digit shows the glyph of its nibble.
  - Nibbles 0xA-0xF show a dash (g segment only).
  - LZ_BLANK = 1: any digit above the most significant nonzero digit is blank. Digit 0 is never blanked, so score 0 shows "0".
- Lost mode phase FSM:
  - States and order: P_YOU -> P_BLANK_A -> P_LOSE -> P_BLANK_B -> P_YOU.
  - Each phase lasts BLINK_DIV cycles, timed by the blink prescaler counting 0..BLINK_DIV-1.
  - A rising edge of lost (lost = 1, lost_q = 0) forces phase P_YOU and clears the blink prescaler on that edge, so each loss always starts with "YOU".
  - While lost = 0, the phase FSM and blink prescaler hold at reset values.
  - Dropping lost returns to score mode on the next registered output. There is no finishing of the current phase.
- Message placement (right-aligned):
  - P_YOU: digits 2,1,0 = Y,O,U.
  - P_LOSE: digits 3,2,1,0 = L,O,S,E.
  - All other digits, and all digits in blank phases, are blank (LED_out = 7'h7F) with the anode still scanned.
- Glyphs, active-high {g..a} before inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Y=1101110, O=0111111, U=0111110, L=0111000, S=1101101, E=1111001, dash=1000000.
- Simultaneous events:
  - A refresh wrap and a blink wrap in the same cycle are both applied.
  - A lost rising edge in the same cycle as a blink terminal count lands in P_YOU with the prescaler at 0; the edge takes priority.
- Width rules:
  - Prescaler widths are $clog2 of their divisors.
  - The index width is $clog2(NUM_DIGITS), with a minimum of 1.
  - No counter may overflow past its divisor.

Decomposition:
- Package seg7_pkg holds:
  - the 7-bit glyph constants (digits 0-9, Y O U L S E, DASH, BLANK);
  - the phase enum (P_YOU, P_BLANK_A, P_LOSE, P_BLANK_B);
  - the function bcd_to_seg(nibble).
- One sub-module, seg7_prescaler (parameter DIV; ports clk, rst, clr, tick), is instantiated twice: once for refresh and once for blink.
- The rest (index counter, phase FSM, glyph mux, leading-zero logic, output registers) lives in seg7_scan_driver.

Test Plan:
- Reset: assert rst mid-scan with no clock edge -> Anode_Activate = 4'b1111 and LED_out = 7'h7F immediately. After release, the first lit digit is digit 0.
- Scan order (REFRESH_DIV = 4, score_bcd = 16'h1234, en = 1):
  - Anode sequence is 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
  - LED_out = ~glyph of 4, 3, 2, 1 respectively.
  - Each output appears 1 cycle after its index change.
- Leading zeros:
  - score_bcd = 16'h0070 -> digits 3 and 2 blank (7'h7F), digit 1 = ~7, digit 0 = ~0.
  - score_bcd = 16'h0000 -> only digit 0 lit, showing "0".
  - score_bcd = 16'h00A5 -> digit 1 shows dash (7'b0111111 after inversion).
- Lost sequence (BLINK_DIV = 8, REFRESH_DIV = 2):
  - Raise lost -> 8 cycles of " YOU", then 8 blank, then 8 of "LOSE", then 8 blank, then " YOU" again.
  - Check digit 3 during P_YOU is 7'h7F.
- Lost re-entry: drop lost mid-P_LOSE -> the score is shown on the next output. Re-raise lost -> P_YOU from a full BLINK_DIV count.
- en = 0 in both modes -> Anode_Activate = all ones while the index keeps advancing. Raise en -> the scan resumes at the current index with no restart.
